// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver.
// Collects framed serial bits (SFRM marks bit 0) into WIDTH-bit words and
// presents each completed word on a valid/ready port through a holding
// register, so the next word can be shifted in while the previous one waits.
module sipo_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             C,
    input  logic             RST,
    input  logic             SI,
    input  logic             SV,
    input  logic             SFRM,
    output logic [WIDTH-1:0] PO,
    output logic             PV,
    input  logic             PR,
    output logic             BUSY,
    output logic             OVF,
    output logic             ERR,
    input  logic             CLR_ERR
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_SHIFT = 1'b1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] r_po;
    logic             r_pv;
    logic             r_ovf;
    logic             r_err;

    logic [0:0]       w_state;
    logic [CW-1:0]    w_cnt;
    logic [WIDTH-1:0] w_sreg;
    logic [WIDTH-1:0] w_shifted;
    logic             w_done;
    logic             w_abort;
    logic             w_load;
    logic             w_drop;
    logic             w_pop;

    // Shift register with the incoming bit inserted at the configured end
    always_comb begin
        w_shifted = r_sreg;
        if (LSB_FIRST) begin
            w_shifted = {SI, r_sreg[WIDTH-1:1]};
        end else begin
            w_shifted = {r_sreg[WIDTH-2:0], SI};
        end
    end

    // Receive FSM: framing, bit counting, completion and abort detection
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_sreg  = r_sreg;
        w_done  = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Unframed bits while idle are silently ignored
                if (SV && SFRM) begin
                    w_sreg  = w_shifted;
                    w_cnt   = CNT_ONE;
                    w_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (SV) begin
                    w_sreg = w_shifted;
                    if (SFRM) begin
                        // Restart: this bit becomes bit 0 of a new word
                        w_abort = 1'b1;
                        w_cnt   = CNT_ONE;
                    end else if (r_cnt == CNT_LAST) begin
                        w_done  = 1'b1;
                        w_cnt   = '0;
                        w_state = ST_IDLE;
                    end else begin
                        w_cnt = r_cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_cnt   = '0;
            end
        endcase
    end

    // Holding-register handshake: load, drop on overflow, or pop
    always_comb begin
        w_load = w_done && (!r_pv || PR);
        w_drop = w_done && r_pv && !PR;
        w_pop  = r_pv && PR && !w_done;
    end

    // State update; reset discards any partial or held word
    always_ff @(posedge C) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sreg  <= '0;
            r_po    <= '0;
            r_pv    <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_sreg  <= w_sreg;
            if (w_load) begin
                r_po <= w_sreg;
                r_pv <= 1'b1;
            end else if (w_pop) begin
                r_pv <= 1'b0;
            end
            // A set event on the same edge as CLR_ERR keeps the flag set
            r_ovf <= (r_ovf && !CLR_ERR) || w_drop;
            r_err <= (r_err && !CLR_ERR) || w_abort;
        end
    end

    assign PO   = r_po;
    assign PV   = r_pv;
    assign BUSY = (r_state == ST_SHIFT);
    assign OVF  = r_ovf;
    assign ERR  = r_err;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: one LSB-first and one MSB-first instance share
// the same stimulus; a word-level model predicts both every cycle, and
// directed literal checks pin the model to hand-computed values.
module tb_sipo_deserializer;

    logic       C;
    logic       RST;
    logic       SI;
    logic       SV;
    logic       SFRM;
    logic       PR;
    logic       CLR_ERR;
    logic [7:0] po_w   [2];
    logic       pv_w   [2];
    logic       busy_w [2];
    logic       ovf_w  [2];
    logic       err_w  [2];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .C(C), .RST(RST), .SI(SI), .SV(SV), .SFRM(SFRM),
        .PO(po_w[0]), .PV(pv_w[0]), .PR(PR), .BUSY(busy_w[0]),
        .OVF(ovf_w[0]), .ERR(err_w[0]), .CLR_ERR(CLR_ERR)
    );

    sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .C(C), .RST(RST), .SI(SI), .SV(SV), .SFRM(SFRM),
        .PO(po_w[1]), .PV(pv_w[1]), .PR(PR), .BUSY(busy_w[1]),
        .OVF(ovf_w[1]), .ERR(err_w[1]), .CLR_ERR(CLR_ERR)
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: bit k of a frame lands at position k (LSB-first)
    // or 7-k (MSB-first); index 0 is the LSB-first instance.
    logic [7:0] m_word [2];
    logic [7:0] m_po   [2];
    bit         m_pv   [2];
    bit         m_busy [2];
    bit         m_ovf  [2];
    bit         m_err  [2];
    int         m_idx  [2];

    always @(posedge C) begin
        for (int d = 0; d < 2; d++) begin
            bit done;
            bit set_ovf;
            bit set_err;
            int pos;
            done    = 1'b0;
            set_ovf = 1'b0;
            set_err = 1'b0;
            if (RST) begin
                m_word[d] = '0; m_po[d] = '0; m_pv[d] = 1'b0; m_busy[d] = 1'b0;
                m_ovf[d] = 1'b0; m_err[d] = 1'b0; m_idx[d] = 0;
            end else begin
                if (SV && (SFRM || m_busy[d])) begin
                    if (SFRM) begin
                        if (m_busy[d]) set_err = 1'b1;
                        m_idx[d]  = 0;
                        m_busy[d] = 1'b1;
                    end
                    pos = (d == 0) ? m_idx[d] : 7 - m_idx[d];
                    m_word[d][pos] = SI;
                    if (m_idx[d] == 7) begin
                        done      = 1'b1;
                        m_busy[d] = 1'b0;
                        m_idx[d]  = 0;
                    end else begin
                        m_idx[d]++;
                    end
                end
                if (done) begin
                    if (!m_pv[d] || PR) begin
                        m_po[d] = m_word[d];
                        m_pv[d] = 1'b1;
                    end else begin
                        set_ovf = 1'b1;
                    end
                end else if (m_pv[d] && PR) begin
                    m_pv[d] = 1'b0;
                end
                m_ovf[d] = (m_ovf[d] && !CLR_ERR) || set_ovf;
                m_err[d] = (m_err[d] && !CLR_ERR) || set_err;
            end
        end
    end

    // Compare both instances against the model away from the active edge
    always @(negedge C) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("model_po[%0d]", d), {24'd0, po_w[d]}, {24'd0, m_po[d]});
                chk($sformatf("model_pv[%0d]", d), {31'd0, pv_w[d]}, {31'd0, m_pv[d]});
                chk($sformatf("model_busy[%0d]", d), {31'd0, busy_w[d]}, {31'd0, m_busy[d]});
                chk($sformatf("model_ovf[%0d]", d), {31'd0, ovf_w[d]}, {31'd0, m_ovf[d]});
                chk($sformatf("model_err[%0d]", d), {31'd0, err_w[d]}, {31'd0, m_err[d]});
            end
        end
    end

    task automatic step();
        @(posedge C);
        #1;
    endtask

    // Send nbits of w as a frame; optionally raise PR with bit pr_bit and
    // insert a 3-cycle SV gap after bit gap_after.
    task automatic send(input logic [7:0] w, input bit lsb, input int nbits,
                        input int pr_bit, input int gap_after);
        for (int i = 0; i < nbits; i++) begin
            SI   = lsb ? w[i] : w[7-i];
            SV   = 1'b1;
            SFRM = (i == 0);
            if (i == pr_bit) PR = 1'b1;
            step();
            if (i == gap_after) begin
                SV   = 1'b0;
                SFRM = 1'b0;
                SI   = ~SI;
                repeat (3) step();
            end
        end
        SV   = 1'b0;
        SFRM = 1'b0;
    endtask

    initial begin
        RST = 1'b1; SI = 1'b0; SV = 1'b0; SFRM = 1'b0; PR = 1'b0; CLR_ERR = 1'b0;
        step();
        cmp_en = 1'b1;
        step();
        RST = 1'b0;
        chk("reset_po", {24'd0, po_w[0]}, 32'h0);
        chk("reset_pv", {31'd0, pv_w[0]}, 32'h0);
        chk("reset_busy", {31'd0, busy_w[0]}, 32'h0);
        // An unframed bit while idle is ignored
        SV = 1'b1; SI = 1'b1;
        step();
        SV = 1'b0;
        chk("idle_unframed_busy", {31'd0, busy_w[0]}, 32'h0);

        // 1: LSB-first 8'hB4, PR=1 -> PV for exactly one cycle
        PR = 1'b1;
        send(8'hB4, 1'b1, 8, -1, -1);
        chk("t1_po", {24'd0, po_w[0]}, 32'hB4);
        chk("t1_pv", {31'd0, pv_w[0]}, 32'h1);
        chk("t1_busy_after", {31'd0, busy_w[0]}, 32'h0);
        step();
        chk("t1_pv_drop", {31'd0, pv_w[0]}, 32'h0);

        // 2: MSB-first bits 1,0,1,1,0,1,0,0
        send(8'hB4, 1'b0, 8, -1, -1);
        chk("t2_po_msb", {24'd0, po_w[1]}, 32'hB4);
        chk("t2_po_lsb", {24'd0, po_w[0]}, 32'h2D);
        step();

        // 3: PR=0, 8'h12 then 8'h34 back-to-back -> overflow, 8'h12 held
        PR = 1'b0;
        send(8'h12, 1'b1, 8, -1, -1);
        chk("t3_first_pv", {31'd0, pv_w[0]}, 32'h1);
        send(8'h34, 1'b1, 8, -1, -1);
        chk("t3_po_held", {24'd0, po_w[0]}, 32'h12);
        chk("t3_ovf", {31'd0, ovf_w[0]}, 32'h1);
        PR = 1'b1;
        step();
        chk("t3_pop_pv", {31'd0, pv_w[0]}, 32'h0);
        chk("t3_pop_po", {24'd0, po_w[0]}, 32'h12);
        CLR_ERR = 1'b1;
        step();
        CLR_ERR = 1'b0;
        chk("t3_ovf_clr", {31'd0, ovf_w[0]}, 32'h0);

        // 4: hold 8'h12, PR rises exactly on completion of 8'h56
        PR = 1'b0;
        send(8'h12, 1'b1, 8, -1, -1);
        send(8'h56, 1'b1, 8, 7, -1);
        chk("t4_po", {24'd0, po_w[0]}, 32'h56);
        chk("t4_pv", {31'd0, pv_w[0]}, 32'h1);
        chk("t4_ovf", {31'd0, ovf_w[0]}, 32'h0);
        step();

        // 5: SFRM re-asserted at bit 5, then a full 8'hA5
        send(8'h3C, 1'b1, 5, -1, -1);
        send(8'hA5, 1'b1, 8, -1, -1);
        chk("t5_err", {31'd0, err_w[0]}, 32'h1);
        chk("t5_po", {24'd0, po_w[0]}, 32'hA5);
        CLR_ERR = 1'b1;
        step();
        CLR_ERR = 1'b0;
        chk("t5_err_clr", {31'd0, err_w[0]}, 32'h0);
        // Abort on the same edge as CLR_ERR: the set wins
        send(8'h0F, 1'b1, 3, -1, -1);
        SI = 1'b1; SV = 1'b1; SFRM = 1'b1; CLR_ERR = 1'b1;
        step();
        SV = 1'b0; SFRM = 1'b0; CLR_ERR = 1'b0;
        chk("t5_set_wins", {31'd0, err_w[0]}, 32'h1);

        // 6: reset mid-word with a held word, then clean frames with gaps
        PR = 1'b0;
        send(8'h12, 1'b1, 8, -1, -1);
        send(8'hC3, 1'b1, 4, -1, -1);
        RST = 1'b1; SV = 1'b1; SI = 1'b1;
        step();
        RST = 1'b0; SV = 1'b0;
        chk("t6_rst_po", {24'd0, po_w[0]}, 32'h0);
        chk("t6_rst_pv", {31'd0, pv_w[0]}, 32'h0);
        chk("t6_rst_busy", {31'd0, busy_w[0]}, 32'h0);
        chk("t6_rst_ovf", {31'd0, ovf_w[0]}, 32'h0);
        chk("t6_rst_err", {31'd0, err_w[0]}, 32'h0);
        PR = 1'b1;
        send(8'hC3, 1'b1, 8, -1, -1);
        chk("t6_po", {24'd0, po_w[0]}, 32'hC3);
        send(8'h5A, 1'b1, 8, -1, -1);
        chk("t6_po_5a", {24'd0, po_w[0]}, 32'h5A);
        send(8'hC3, 1'b1, 8, -1, 3);
        chk("t6_gap_po", {24'd0, po_w[0]}, 32'hC3);
        chk("t6_gap_po_msb", {24'd0, po_w[1]}, 32'hC3);
        chk("t6_gap_pv", {31'd0, pv_w[0]}, 32'h1);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
